fft_out_pingpong_packer: RTL and testbench
==========================================

// Module: fft_out_pingpong_packer
// PURPOSE
//  Parametrised, double-buffered packer for the FFT result stream. Keeps the top KEEP_W bits of the
//  real and imag halves of each FFT word and packs N_WORDS of them into a frame for the SPI.
//  Fills one bank while the other bank is held stable for the SPI consumer.
//  A frame_valid/frame_ack handshake decouples the two sides. Overflow is detected and flagged.
// PARAMETERS
//  N_WORDS  256  FFT words per frame (>=2)
//  IN_W     32   FFT word width; real = [IN_W-1:IN_W/2], imag = [IN_W/2-1:0]
//  KEEP_W   8    MSBs kept from each of real and imag (<= IN_W/2)
//  FRAME_W  = N_WORDS*2*KEEP_W; derived localparam, not overridable
// PORTS
//  clk          in   1                      system clock, all state on rising edge
//  reset        in   1                      asynchronous, active-high; clears all state
//  frame_start  in   1                      restart the fill bank (new FFT frame begins)
//  word_valid   in   1                      word_in valid this cycle (FFT done strobe)
//  word_in      in   IN_W                   FFT output word
//  frame_ack    in   1                      consumer finished with frame_out; releases read bank
//  frame_out    out  FRAME_W                read bank; word 0 in MSBs
//  frame_valid  out  1                      frame_out holds an unconsumed complete frame
//  fill_count   out  $clog2(N_WORDS+1)      words held in fill bank, saturates at N_WORDS
//  fill_full    out  1                      fill bank complete, waiting for read bank release
//  overflow     out  1                      sticky: a word_valid was dropped
// BEHAVIOUR
//  - Reset (async): fill bank=0, frame_out=0, frame_valid=0, fill_count=0, fill_full=0,
//    overflow=0, FSM=FILLING.
//  - Packing: pk = {word_in[IN_W-1 -: KEEP_W], word_in[IN_W/2-1 -: KEEP_W]} (2*KEEP_W bits).
//    On acceptance: fill <= {fill[FRAME_W-2*KEEP_W-1:0], pk}, fill_count+1.
//    After N_WORDS words, word 0 occupies frame bits [FRAME_W-1 -: 2*KEEP_W].
//  - read_free = !frame_valid || frame_ack. frame_ack is ignored while frame_valid=0.
//  - FSM FILLING: word_valid is accepted.
//    * If the accepted word is word N_WORDS-1 and read_free:
//      frame_out <= completed fill (including this word), frame_valid <= 1, fill_count <= 0,
//      fill <= 0; stay FILLING. frame_valid is high on the cycle after the last word.
//    * If the accepted word is word N_WORDS-1 and !read_free:
//      fill_count <= N_WORDS, fill_full <= 1, go to HOLD.
//    * Otherwise, frame_ack with frame_valid=1 clears frame_valid. frame_out holds its old value.
//  - FSM HOLD: word_valid is dropped and sets overflow. Fill contents are frozen.
//    * When read_free: frame_out <= fill, frame_valid stays/becomes 1, fill_count <= 0,
//      fill_full <= 0; go to FILLING. The ack and the new frame occur on the same edge, so
//      frame_valid never dips.
//    * A word_valid arriving in that same transfer cycle is still dropped and flagged as overflow.
//  - frame_start (any state, highest priority after reset): fill <= 0, fill_count <= 0,
//    fill_full <= 0, go to FILLING. The read bank and frame_valid are unaffected.
//    * If word_valid is also high that cycle, the word becomes word 0 (fill_count=1).
//    * A frame_ack on that cycle is still honoured.
//  - frame_out changes only on a bank transfer or on reset. It is stable while frame_valid=1
//    and no ack is given.
//  - overflow is cleared only by reset.
//  - fill_count never exceeds N_WORDS. There is no wrap.
// TESTING
//  1. reset; N_WORDS=4, KEEP_W=8; words 0xAA00BB00, 0x11002200, 0x33004400, 0x55006600
//     -> frame_out=0xAABB_1122_3344_5566, frame_valid=1 one clk after the 4th word,
//        fill_count=0.
//  2. Keep frame_valid=1 (no ack); feed 4 more words -> fill_full=1, fill_count=4, frame_out
//     unchanged. A 5th word sets overflow=1. Then ack -> next edge frame_out=new frame,
//     frame_valid stays 1, fill_full=0.
//  3. Ack on the same cycle as the 4th word of the next frame -> new frame transferred that
//     edge, frame_valid continuously 1, overflow unchanged.
//  4. After 2 words, assert frame_start with word_valid (word 0x77008800) -> fill_count=1.
//     Three more words complete the frame with word 0 = 0x7788. The stale words are absent.
//  5. Assert reset asynchronously mid-fill and during HOLD -> all outputs 0 immediately,
//     without waiting for a clk edge. Normal fill resumes after release.
//  6. Random word_valid/frame_ack stress against a reference model
//     -> frame_out matches the model, no frame lost unless overflow=1.

Source files
------------

// File: rtl/fft_out_pingpong_packer_if.sv
// FFT packer bus: producer-side word stream plus consumer-side frame handshake.
// Widths follow the packer parameters; the packer takes the slave view.
interface fft_out_pingpong_packer_if #(
    parameter int N_WORDS = 256,
    parameter int IN_W    = 32,
    parameter int KEEP_W  = 8
);
    localparam int FRAME_W = N_WORDS * 2 * KEEP_W;
    localparam int CNT_W   = $clog2(N_WORDS + 1);

    logic               frame_start;
    logic               word_valid;
    logic [IN_W-1:0]    word_in;
    logic               frame_ack;
    logic [FRAME_W-1:0] frame_out;
    logic               frame_valid;
    logic [CNT_W-1:0]   fill_count;
    logic               fill_full;
    logic               overflow;

    modport master (
        output frame_start, word_valid, word_in, frame_ack,
        input  frame_out, frame_valid, fill_count, fill_full, overflow
    );

    modport slave (
        input  frame_start, word_valid, word_in, frame_ack,
        output frame_out, frame_valid, fill_count, fill_full, overflow
    );
endinterface

// File: rtl/fft_out_pingpong_packer.sv
// Ping-pong packer: truncates FFT words to real/imag MSBs and packs N_WORDS into a frame bank.
// Latency: frame_valid/frame_out update on the edge that accepts the last word (or releases HOLD).
// Backpressure: none upstream; a full fill bank with an unacked read bank drops words and sets overflow.
module fft_out_pingpong_packer #(
    parameter int N_WORDS = 256,
    parameter int IN_W    = 32,
    parameter int KEEP_W  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    fft_out_pingpong_packer_if.slave   bus_if
);
    localparam int PK_W    = 2 * KEEP_W;
    localparam int FRAME_W = N_WORDS * PK_W;
    localparam int CNT_W   = $clog2(N_WORDS + 1);

    typedef enum logic {
        FILLING = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t             state_q;
    logic [FRAME_W-1:0] fill_q;
    logic [FRAME_W-1:0] frame_q;
    logic               frame_vld_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               full_q;
    logic               ovf_q;

    logic [PK_W-1:0]    pk;
    logic [FRAME_W-1:0] fill_d;
    logic [FRAME_W-1:0] fill_first_d;
    logic               read_free;
    logic               last_word;

    assign pk           = {bus_if.word_in[IN_W-1 -: KEEP_W], bus_if.word_in[IN_W/2-1 -: KEEP_W]};
    assign fill_d       = {fill_q[FRAME_W-PK_W-1:0], pk};
    assign fill_first_d = {{(FRAME_W-PK_W){1'b0}}, pk};
    assign read_free    = !frame_vld_q || bus_if.frame_ack;
    assign last_word    = (cnt_q == CNT_W'(N_WORDS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FILLING;
            fill_q      <= '0;
            frame_q     <= '0;
            frame_vld_q <= 1'b0;
            cnt_q       <= '0;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            // An ack releases the read bank; a transfer below re-asserts valid on the same edge.
            if (frame_vld_q && bus_if.frame_ack) begin
                frame_vld_q <= 1'b0;
            end

            if (bus_if.frame_start) begin
                state_q <= FILLING;
                full_q  <= 1'b0;
                if (bus_if.word_valid) begin
                    fill_q <= fill_first_d;
                    cnt_q  <= CNT_W'(1);
                end else begin
                    fill_q <= '0;
                    cnt_q  <= '0;
                end
            end else begin
                case (state_q)
                    FILLING: begin
                        if (bus_if.word_valid) begin
                            if (last_word && read_free) begin
                                frame_q     <= fill_d;
                                frame_vld_q <= 1'b1;
                                fill_q      <= '0;
                                cnt_q       <= '0;
                            end else if (last_word) begin
                                fill_q  <= fill_d;
                                cnt_q   <= CNT_W'(N_WORDS);
                                full_q  <= 1'b1;
                                state_q <= HOLD;
                            end else begin
                                fill_q <= fill_d;
                                cnt_q  <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    HOLD: begin
                        // Fill bank is frozen: any word arriving here, even on the release edge, is lost.
                        if (bus_if.word_valid) begin
                            ovf_q <= 1'b1;
                        end
                        if (read_free) begin
                            frame_q     <= fill_q;
                            frame_vld_q <= 1'b1;
                            fill_q      <= '0;
                            cnt_q       <= '0;
                            full_q      <= 1'b0;
                            state_q     <= FILLING;
                        end
                    end
                    default: begin
                        state_q <= FILLING;
                    end
                endcase
            end
        end
    end

    assign bus_if.frame_out   = frame_q;
    assign bus_if.frame_valid = frame_vld_q;
    assign bus_if.fill_count  = cnt_q;
    assign bus_if.fill_full   = full_q;
    assign bus_if.overflow    = ovf_q;
endmodule

// File: tb/tb_fft_out_pingpong_packer.sv
// Bench for fft_out_pingpong_packer: directed scenarios plus random stress with a frame scoreboard.
module tb_fft_out_pingpong_packer;
    localparam int N      = 4;
    localparam int IN_W   = 32;
    localparam int KEEP_W = 8;
    localparam int FW     = N * 2 * KEEP_W;
    localparam int CW     = $clog2(N + 1);

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fft_out_pingpong_packer_if #(.N_WORDS(N), .IN_W(IN_W), .KEEP_W(KEEP_W)) bus ();

    fft_out_pingpong_packer #(.N_WORDS(N), .IN_W(IN_W), .KEEP_W(KEEP_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: raw words kept in arrival order, packed only when a frame is handed over.
    logic [31:0]   m_w [N];
    int            m_cnt;
    bit            m_hold;
    bit            m_vld;
    bit            m_ovf;
    logic [FW-1:0] m_frame;
    logic [FW-1:0] exp_q [$];

    function logic [FW-1:0] pack_words();
        logic [FW-1:0] f;
        f = '0;
        for (int i = 0; i < N; i++) begin
            f[FW-1-16*i -: 16] = {m_w[i][31:24], m_w[i][15:8]};
        end
        return f;
    endfunction

    task automatic mdl_reset();
        m_cnt = 0; m_hold = 0; m_vld = 0; m_ovf = 0; m_frame = '0;
        for (int i = 0; i < N; i++) m_w[i] = '0;
        exp_q.delete();
    endtask

    task automatic mdl_edge(input bit fs, input bit wv, input logic [31:0] w, input bit ack);
        bit rf;
        bit n_vld;
        rf    = !m_vld || ack;
        n_vld = m_vld && !ack;
        if (fs) begin
            m_hold = 0;
            m_cnt  = 0;
            if (wv) begin
                m_w[0] = w;
                m_cnt  = 1;
            end
        end else if (!m_hold) begin
            if (wv) begin
                m_w[m_cnt] = w;
                m_cnt++;
                if (m_cnt == N) begin
                    if (rf) begin
                        m_frame = pack_words();
                        exp_q.push_back(m_frame);
                        n_vld = 1;
                        m_cnt = 0;
                    end else begin
                        m_hold = 1;
                    end
                end
            end
        end else begin
            if (wv) m_ovf = 1;
            if (rf) begin
                m_frame = pack_words();
                exp_q.push_back(m_frame);
                n_vld  = 1;
                m_cnt  = 0;
                m_hold = 0;
            end
        end
        m_vld = n_vld;
    endtask

    task automatic step(input bit fs, input bit wv, input logic [31:0] w, input bit ack);
        bus.frame_start = fs;
        bus.word_valid  = wv;
        bus.word_in     = w;
        bus.frame_ack   = ack;
        @(posedge clk);
        mdl_edge(fs, wv, w, ack);
        #1;
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        bus.frame_start = 1'b0;
        bus.word_valid  = 1'b0;
        bus.word_in     = '0;
        bus.frame_ack   = 1'b0;
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.frame_out !== '0 || bus.frame_valid !== 1'b0 || bus.fill_count !== '0 ||
            bus.fill_full !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out=%h vld=%b cnt=%0d full=%b ovf=%b required all zero",
                     bus.frame_out, bus.frame_valid, bus.fill_count, bus.fill_full, bus.overflow);
        end
    endtask

    task automatic test_basic_frame();
        logic [31:0] words [4];
        words = '{32'hAA00BB00, 32'h11002200, 32'h33004400, 32'h55006600};
        for (int i = 0; i < 3; i++) step(0, 1, words[i], 0);
        checks++;
        if (bus.frame_valid !== 1'b0 || bus.fill_count !== CW'(3)) begin
            errors++;
            $display("FAIL basic_partial: vld=%b cnt=%0d required vld=0 cnt=3", bus.frame_valid, bus.fill_count);
        end
        step(0, 1, words[3], 0);
        checks++;
        if (bus.frame_out !== 64'hAABB_1122_3344_5566 || bus.frame_valid !== 1'b1 || bus.fill_count !== '0) begin
            errors++;
            $display("FAIL basic_frame: out=%h vld=%b cnt=%0d required out=aabb112233445566 vld=1 cnt=0",
                     bus.frame_out, bus.frame_valid, bus.fill_count);
        end
    endtask

    task automatic test_hold_overflow();
        logic [31:0] words [4];
        words = '{32'h12003400, 32'h56007800, 32'h9A00BC00, 32'hDE00F000};
        for (int i = 0; i < 4; i++) step(0, 1, words[i], 0);
        checks++;
        if (bus.fill_full !== 1'b1 || bus.fill_count !== CW'(4) || bus.frame_out !== 64'hAABB_1122_3344_5566 ||
            bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL hold_entry: full=%b cnt=%0d out=%h ovf=%b required full=1 cnt=4 out=aabb112233445566 ovf=0",
                     bus.fill_full, bus.fill_count, bus.frame_out, bus.overflow);
        end
        step(0, 1, 32'hFFFFFFFF, 0);
        checks++;
        if (bus.overflow !== 1'b1 || bus.fill_full !== 1'b1) begin
            errors++;
            $display("FAIL hold_overflow: ovf=%b full=%b required ovf=1 full=1", bus.overflow, bus.fill_full);
        end
        step(0, 0, 32'h0, 1);
        checks++;
        if (bus.frame_out !== 64'h1234_5678_9ABC_DEF0 || bus.frame_valid !== 1'b1 || bus.fill_full !== 1'b0 ||
            bus.fill_count !== '0) begin
            errors++;
            $display("FAIL hold_release: out=%h vld=%b full=%b cnt=%0d required out=123456789abcdef0 vld=1 full=0 cnt=0",
                     bus.frame_out, bus.frame_valid, bus.fill_full, bus.fill_count);
        end
    endtask

    task automatic test_ack_on_last();
        logic [31:0] words [4];
        words = '{32'h10002000, 32'h30004000, 32'h50006000, 32'h70008000};
        for (int i = 0; i < 4; i++) begin
            step(0, 1, words[i], (i == 3));
            checks++;
            if (bus.frame_valid !== 1'b1) begin
                errors++;
                $display("FAIL ack_last_valid[%0d]: vld=%b required 1", i, bus.frame_valid);
            end
        end
        checks++;
        if (bus.frame_out !== 64'h1020_3040_5060_7080 || bus.overflow !== 1'b1 || bus.fill_full !== 1'b0) begin
            errors++;
            $display("FAIL ack_last_frame: out=%h ovf=%b full=%b required out=1020304050607080 ovf=1 full=0",
                     bus.frame_out, bus.overflow, bus.fill_full);
        end
    endtask

    task automatic test_frame_start();
        step(0, 0, 32'h0, 1);
        step(0, 1, 32'hEE00EE00, 0);
        step(0, 1, 32'hDD00DD00, 0);
        step(1, 1, 32'h77008800, 0);
        checks++;
        if (bus.fill_count !== CW'(1) || bus.frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL restart_count: cnt=%0d vld=%b required cnt=1 vld=0", bus.fill_count, bus.frame_valid);
        end
        step(0, 1, 32'h99001100, 0);
        step(0, 1, 32'h22003300, 0);
        step(0, 1, 32'h44005500, 0);
        checks++;
        if (bus.frame_out !== 64'h7788_9911_2233_4455 || bus.frame_valid !== 1'b1) begin
            errors++;
            $display("FAIL restart_frame: out=%h vld=%b required out=7788991122334455 vld=1",
                     bus.frame_out, bus.frame_valid);
        end
    endtask

    task automatic async_reset_pulse(input string tag);
        bus.frame_start = 1'b0;
        bus.word_valid  = 1'b0;
        bus.frame_ack   = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        mdl_reset();
        #1;
        checks++;
        if (bus.frame_out !== '0 || bus.frame_valid !== 1'b0 || bus.fill_count !== '0 ||
            bus.fill_full !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_%s: out=%h vld=%b cnt=%0d full=%b ovf=%b required all zero", tag,
                     bus.frame_out, bus.frame_valid, bus.fill_count, bus.fill_full, bus.overflow);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_async_reset();
        step(0, 1, 32'h01000200, 0);
        step(0, 1, 32'h03000400, 0);
        async_reset_pulse("midfill");
        for (int i = 0; i < 9; i++) step(0, 1, 32'h0A000B00 + i, 0);
        checks++;
        if (bus.fill_full !== 1'b1 || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL hold_setup: full=%b ovf=%b required full=1 ovf=1", bus.fill_full, bus.overflow);
        end
        async_reset_pulse("hold");
        step(0, 1, 32'hC000C100, 0);
        step(0, 1, 32'hC200C300, 0);
        step(0, 1, 32'hC400C500, 0);
        step(0, 1, 32'hC600C700, 0);
        checks++;
        if (bus.frame_out !== 64'hC0C1_C2C3_C4C5_C6C7 || bus.frame_valid !== 1'b1 || bus.fill_count !== '0) begin
            errors++;
            $display("FAIL post_reset_frame: out=%h vld=%b cnt=%0d required out=c0c1c2c3c4c5c6c7 vld=1 cnt=0",
                     bus.frame_out, bus.frame_valid, bus.fill_count);
        end
    endtask

    task automatic test_random_stress();
        logic [FW-1:0] prev_out;
        logic          prev_vld;
        logic [FW-1:0] exp_f;
        int            frames;
        frames = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            prev_out = bus.frame_out;
            prev_vld = bus.frame_valid;
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 4) == 0));
            if (bus.frame_out !== prev_out || (bus.frame_valid && !prev_vld)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stress_unexpected_frame: cycle=%0d out=%h required no new frame", c, bus.frame_out);
                end else begin
                    exp_f = exp_q.pop_front();
                    frames++;
                    if (bus.frame_out !== exp_f) begin
                        errors++;
                        $display("FAIL stress_frame: cycle=%0d out=%h required %h", c, bus.frame_out, exp_f);
                    end
                end
            end
            checks++;
            if (bus.frame_valid !== m_vld || bus.fill_count !== CW'(m_cnt) || bus.fill_full !== m_hold ||
                bus.overflow !== m_ovf) begin
                errors++;
                $display("FAIL stress_status: cycle=%0d vld=%b cnt=%0d full=%b ovf=%b required vld=%b cnt=%0d full=%b ovf=%b",
                         c, bus.frame_valid, bus.fill_count, bus.fill_full, bus.overflow,
                         m_vld, m_cnt, m_hold, m_ovf);
            end
        end
        checks++;
        if (exp_q.size() != 0 || frames == 0) begin
            errors++;
            $display("FAIL stress_frames_lost: pending=%0d seen=%0d required pending=0 seen>0", exp_q.size(), frames);
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        bus.frame_start = 1'b0;
        bus.word_valid  = 1'b0;
        bus.word_in     = '0;
        bus.frame_ack   = 1'b0;
        test_reset();
        test_basic_frame();
        test_hold_overflow();
        test_ack_on_last();
        test_frame_start();
        test_async_reset();
        test_random_stress();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
